instruction_fetch_phase: RTL
============================

# instruction_fetch_phase

Front end of the 5-stage MIPS pipeline and producer side of the IF/ID interface consumed by the decode stage. Holds the PC and issues fetches to instruction memory over a request/response handshake. Drives the IF/ID register (`instr_out`, `pc_out` = PC+4, `valid_out`) and applies branch, jump and jump-register redirects coming back from decode. Supports load-use stall and wrong-path flush; the pipeline has no branch delay slot.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0000, instruction word driven on a bubble
- `Clk`  in  1  clock; all state updates on the rising edge
- `Reset`  in  1  asynchronous, active-low (0 = reset asserted)
- `Stall`  in  1  hold the PC and the IF/ID register
- `Branch`, `Jump`, `JumpRegister`  in  1 each  taken-redirect requests from decode
- `BranchTarget`, `JumpTarget`, `JumpRegTarget`  in  32 each  redirect targets; `JumpRegTarget` is the rs value
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch address (current PC)
- `imem_ready`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid
- `imem_rdata`  in  32  instruction word
- `instr_out`  out  32  IF/ID instruction
- `pc_out`  out  32  IF/ID PC+4
- `valid_out`  out  1  IF/ID holds a real instruction

## Operation
- FSM states and behaviour:
  - IDLE: entered on reset; always moves to REQ on the next cycle.
  - REQ: `imem_req`=1 and `imem_addr`=PC; `imem_ready`=1 moves to WAIT.
  - WAIT: on `imem_rvalid`, either capture the response or, if `Stall`=1, move to HOLD.
  - HOLD: one-entry buffer holding {word, PC}.
  - DROP: discard the next `imem_rvalid`, then move to REQ.
- At most one fetch is outstanding. `imem_req` is 0 in every state except REQ.
- Capture (WAIT with `rvalid`=1 and `Stall`=0, or HOLD with `Stall`=0):
  - `instr_out` <= word, `pc_out` <= PC+4, `valid_out` <= 1, PC <= PC+4.
  - Next state is REQ.
- Stall (`Stall`=1):
  - IF/ID holds and the PC holds.
  - REQ still issues its request.
  - A response arriving in WAIT is buffered and the FSM moves to HOLD.
- Redirect:
  - Qualifier: `redirect` = (`Branch` | `Jump` | `JumpRegister`) & `valid_out` & ~`Stall`.
  - Target priority: `JumpRegister` > `Jump` > `Branch`.
  - Effect: PC <= target, and IF/ID is flushed on the same edge (`instr_out`=NOP, `valid_out`=0, `pc_out` holds).
  - Per state:
    - REQ: the unaccepted request is withdrawn, and the FSM stays in REQ with the new address. This applies even if `imem_ready`=1 in the same cycle; that acceptance is treated as stale, so the next state is DROP.
    - WAIT without `rvalid`: move to DROP.
    - WAIT with `rvalid`: discard the data and move to REQ.
    - HOLD: discard the buffer and move to REQ.
    - DROP: update the PC and stay in DROP.
- With no capture and no redirect, IF/ID holds its value. `valid_out` stays 1 until it is flushed or overwritten.
- PC arithmetic is modulo 2^32; 0xFFFF_FFFC+4 wraps to 0. PC bits [1:0] are always 0, and target bits [1:0] are ignored.

## Timing
- Reset values: PC=`RESET_PC`, `instr_out`=NOP, `pc_out`=0, `valid_out`=0, `imem_req`=0, state IDLE.
- Reset asserted mid-operation forces the reset values immediately. Any in-flight response is ignored until the FSM re-enters WAIT.
- First `imem_req`=1 occurs in the second cycle after `Reset` deasserts.
- Accept at cycle t with `rvalid` at t+1 gives IF/ID updated at the t+1 edge and the next request at t+2. Peak rate is 1 instruction per 2 cycles; latency grows with memory wait states.
- A redirect seen in cycle t produces `imem_addr`=target at the earliest in cycle t+1, or after the dropped response arrives.
- HOLD to capture takes effect on the first edge with `Stall`=0.

## Structure
- Shared package `fetch_defs`: FSM state encodings (IDLE, REQ, WAIT, HOLD, DROP), NOP constant, PC increment constant 4.
- One sub-module, `fetch_pc_register`: 32-bit PC with async active-low reset to `RESET_PC`, load-target, increment and hold.
- IF/ID register and FSM live in the top module.

## Test plan
- Reset: `Reset` low during WAIT with `rvalid` pulsing -> all outputs at reset values. After release, the first `imem_addr`=0x0 and no capture comes from the stale response.
- Sequential fetch: `imem_ready`=1 and 1-cycle `rvalid`, `rdata`=0x2000_0000+addr -> `pc_out` goes 0x4, 0x8, 0xC at one instruction per 2 cycles, and `instr_out` matches the data.
- Stall: `Stall`=1 for 3 cycles while a response (0x8C41_0004, addr 0x8) returns -> IF/ID unchanged and no new `imem_req`. One edge after `Stall`=0, `instr_out`=0x8C41_0004 and `pc_out`=0xC.
- Branch in WAIT: `Branch`=1, `BranchTarget`=0x100, response still pending -> next edge `valid_out`=0. The pending response is dropped, the next `imem_addr`=0x100, and the captured `pc_out`=0x104.
- Priority: `JumpRegister`=`Jump`=1 with `JumpRegTarget`=0x40 and `JumpTarget`=0x80 -> next fetch at 0x40.
- Qualified redirect: `Branch`=1 with `Stall`=1, or with `valid_out`=0 -> no PC change and no flush.

Source files
------------

// File: rtl/instruction_fetch_phase_pkg.sv
// Shared definitions for the MIPS instruction fetch stage: FSM encoding and fetch constants.
package fetch_defs;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDrop
    } fetch_state_e;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    // Instruction addresses are word aligned; the two low bits carry no information.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_phase_if.sv
// Instruction memory request/response channel between the fetch stage and instruction memory.
interface instruction_fetch_phase_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/instruction_fetch_phase_pc_register.sv
// Program counter: loads a redirect target, advances by one word, or holds.
module fetch_pc_register
    import fetch_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] target_i,
    input  logic        inc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // A redirect outranks sequential advance when both are requested.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(target_i);
        end else if (inc_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_phase.sv
// MIPS fetch stage: issues one fetch at a time, fills the IF/ID register, applies redirects.
module instruction_fetch_phase
    import fetch_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             Stall,
    input  logic                             Branch,
    input  logic                             Jump,
    input  logic                             JumpRegister,
    input  logic [31:0]                      BranchTarget,
    input  logic [31:0]                      JumpTarget,
    input  logic [31:0]                      JumpRegTarget,
    instruction_fetch_phase_if.master        imem,
    output logic [31:0]                      instr_out,
    output logic [31:0]                      pc_out,
    output logic                             valid_out
);

    fetch_state_e state_q, state_d;
    logic         req_q;
    logic [31:0]  instr_q;
    logic [31:0]  pcout_q;
    logic         valid_q;
    logic [31:0]  hold_word_q;

    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         redirect;
    logic [31:0]  target;
    logic         capture;
    logic         hold_load;
    logic [31:0]  cap_word;

    // Only a real instruction in IF/ID may redirect, and never while decode is stalled.
    assign redirect = (Branch | Jump | JumpRegister) & valid_q & ~Stall;

    always_comb begin
        target = BranchTarget;
        if (JumpRegister) begin
            target = JumpRegTarget;
        end else if (Jump) begin
            target = JumpTarget;
        end
    end

    assign pc_plus4  = pc + PC_INC;
    assign hold_load = (state_q == StWait) & imem.imem_rvalid & Stall;
    assign capture   = ~redirect & ~Stall &
                       (((state_q == StWait) & imem.imem_rvalid) | (state_q == StHold));
    // The PC register holds during HOLD, so only the word needs buffering.
    assign cap_word  = (state_q == StHold) ? hold_word_q : imem.imem_rdata;

    fetch_pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i    (Clk),
        .rst_ni   (Reset),
        .load_i   (redirect),
        .target_i (target),
        .inc_i    (capture),
        .pc_o     (pc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                // An acceptance coinciding with a redirect fetched the wrong path.
                if (imem.imem_ready) begin
                    state_d = redirect ? StDrop : StWait;
                end
            end
            StWait: begin
                if (imem.imem_rvalid) begin
                    state_d = Stall ? StHold : StReq;
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StHold: begin
                if (!Stall) begin
                    state_d = StReq;
                end
            end
            StDrop: begin
                if (imem.imem_rvalid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            instr_q     <= NOP;
            pcout_q     <= 32'h0000_0000;
            valid_q     <= 1'b0;
            hold_word_q <= NOP;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == StReq);
            if (redirect) begin
                instr_q <= NOP;
                valid_q <= 1'b0;
            end else if (capture) begin
                instr_q <= cap_word;
                pcout_q <= pc_plus4;
                valid_q <= 1'b1;
            end
            if (hold_load) begin
                hold_word_q <= imem.imem_rdata;
            end
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign instr_out      = instr_q;
    assign pc_out         = pcout_q;
    assign valid_out      = valid_q;

endmodule
